// File: rtl/mult_seq_chk.sv
// Sequential shift-add multiplier (W steps, one shared adder) with signed/unsigned
// mode and a mod-3 residue check that flags a corrupted product on err.
module mult_seq_chk #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  logic                 sgn,
    input  logic                 fault_inj,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*W-1:0]       p,
    output logic                 err,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam int IW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, BUSY, CHECK, DONE} state_t;

    state_t           state;
    logic [W-1:0]     mcand;
    logic [2*W:0]     acc;
    logic [IW-1:0]    iter;
    logic             neg;
    logic             finj;
    logic [1:0]       ra;
    logic [1:0]       rb;

    logic [W-1:0]     abs_a;
    logic [W-1:0]     abs_b;
    logic [W:0]       sum;
    logic [2*W-1:0]   m;
    logic [2*W-1:0]   rprod;

    // Residue mod 3 folded MSB-first: r <- (2r + bit) mod 3, two bits of state.
    function automatic logic [1:0] mod3(input logic [2*W-1:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 2*W-1; i >= 0; i--) begin
            case ({r, v[i]})
                3'b000:  r = 2'd0;
                3'b001:  r = 2'd1;
                3'b010:  r = 2'd2;
                3'b011:  r = 2'd0;
                3'b100:  r = 2'd1;
                3'b101:  r = 2'd2;
                default: r = 2'd0;
            endcase
        end
        return r;
    endfunction

    // -2^(W-1) negates to 2^(W-1), which still fits as an unsigned W-bit magnitude.
    assign abs_a = (sgn && a[W-1]) ? (~a + 1'b1) : a;
    assign abs_b = (sgn && b[W-1]) ? (~b + 1'b1) : b;

    assign sum   = acc[2*W:W] + {1'b0, mcand};
    assign m     = acc[2*W-1:0] ^ {{(2*W-1){1'b0}}, finj};
    assign rprod = (2*W)'(ra) * (2*W)'(rb);

    // Low W bits of the accumulator start out holding the multiplier and are
    // consumed one bit per step as the partial product shifts in from above.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            p         <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
            acc       <= '0;
            iter      <= '0;
            mcand     <= '0;
            neg       <= 1'b0;
            finj      <= 1'b0;
            ra        <= 2'd0;
            rb        <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= abs_a;
                        acc      <= {{(W+1){1'b0}}, abs_b};
                        neg      <= sgn & (a[W-1] ^ b[W-1]);
                        finj     <= fault_inj;
                        ra       <= mod3((2*W)'(abs_a));
                        rb       <= mod3((2*W)'(abs_b));
                        iter     <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (acc[0]) begin
                        acc <= {sum, acc[W-1:1]};
                    end else begin
                        acc <= {1'b0, acc[2*W:1]};
                    end
                    iter <= iter + 1'b1;
                    if (iter == IW'(W - 1)) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    p         <= neg ? (~m + 1'b1) : m;
                    err       <= (mod3(m) != mod3(rprod));
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                        if (err && (err_cnt != {CNT_W{1'b1}})) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_chk.sv
// Self-checking bench for mult_seq_chk: directed W=4 cases, fault/saturation,
// backpressure, mid-operation reset, a full W=4 sweep and random W=8 traffic.
module tb_mult_seq_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       iv4, ir4, s4, f4, ov4, or4, e4;
    logic [3:0] a4, b4;
    logic [7:0] p4, c4;

    logic        iv8, ir8, s8, f8, ov8, or8, e8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic [7:0]  c8;

    int checks = 0;
    int passed = 0;

    logic [3:0] da [4] = '{4'd15, 4'd8, 4'd8, 4'd0};
    logic [3:0] db [4] = '{4'd15, 4'd8, 4'd7, 4'd15};
    logic       ds [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] dp [4] = '{8'hE1, 8'h40, 8'hC8, 8'h00};

    mult_seq_chk #(.W(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .sgn(s4), .fault_inj(f4), .out_valid(ov4), .out_ready(or4), .p(p4),
        .err(e4), .err_cnt(c4)
    );

    mult_seq_chk #(.W(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .sgn(s8), .fault_inj(f8), .out_valid(ov8), .out_ready(or8), .p(p8),
        .err(e8), .err_cnt(c8)
    );

    // Reference: integer multiply of magnitudes, sign applied afterwards.
    function automatic void model(input int w, input int ua, input int ub, input bit s,
                                  input bit f, output logic [63:0] pe, output bit ee);
        longint sa, sb, ma, mb, m, pv;
        sa = ua;
        sb = ub;
        if (s && ua >= (1 << (w - 1))) sa = longint'(ua) - (longint'(1) << w);
        if (s && ub >= (1 << (w - 1))) sb = longint'(ub) - (longint'(1) << w);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        m  = ma * mb;
        if (f) m = m ^ 1;
        ee = (m % 3) != (((ma % 3) * (mb % 3)) % 3);
        pv = ((sa < 0) != (sb < 0)) ? -m : m;
        pe = 64'(pv) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic start4(input logic [3:0] ia, input logic [3:0] ib, input logic is,
                          input logic ifj);
        int n = 0;
        a4 = ia; b4 = ib; s4 = is; f4 = ifj; iv4 = 1'b1;
        while (!ir4 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        iv4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom); f4 = 1'($urandom);
    endtask

    task automatic wait4(output int lat);
        lat = 0;
        while (!ov4 && lat < 30) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic finish4();
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++; if (ir4 !== 1'b1) $display("[TB] FAIL reset in_ready: got %b want 1", ir4); else passed++;
        checks++; if (ov4 !== 1'b0) $display("[TB] FAIL reset out_valid: got %b want 0", ov4); else passed++;
        checks++; if (p4 !== 8'h00) $display("[TB] FAIL reset p: got %h want 00", p4); else passed++;
        checks++; if (e4 !== 1'b0) $display("[TB] FAIL reset err: got %b want 0", e4); else passed++;
        checks++; if (c4 !== 8'h00) $display("[TB] FAIL reset err_cnt: got %0d want 0", c4); else passed++;
        checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0) $display("[TB] FAIL reset w8 handshake: got ir=%b ov=%b want 1 0", ir8, ov8); else passed++;
    endtask

    task automatic test_directed();
        int lat;
        for (int i = 0; i < 4; i++) begin
            start4(da[i], db[i], ds[i], 1'b0);
            wait4(lat);
            checks++; if (lat != 5) $display("[TB] FAIL directed%0d latency: got %0d want 5", i, lat); else passed++;
            checks++; if (p4 !== dp[i]) $display("[TB] FAIL directed%0d p: got %h want %h", i, p4, dp[i]); else passed++;
            checks++; if (e4 !== 1'b0) $display("[TB] FAIL directed%0d err: got %b want 0", i, e4); else passed++;
            finish4();
        end
    endtask

    task automatic test_fault();
        int lat;
        int missed = 0;
        start4(4'd6, 4'd5, 1'b0, 1'b1);
        wait4(lat);
        checks++; if (p4 !== 8'd31) $display("[TB] FAIL fault p: got %0d want 31", p4); else passed++;
        checks++; if (e4 !== 1'b1) $display("[TB] FAIL fault err: got %b want 1", e4); else passed++;
        checks++; if (c4 !== 8'd0) $display("[TB] FAIL fault err_cnt before: got %0d want 0", c4); else passed++;
        finish4();
        checks++; if (c4 !== 8'd1) $display("[TB] FAIL fault err_cnt after: got %0d want 1", c4); else passed++;
        for (int i = 0; i < 255; i++) begin
            start4(4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
            wait4(lat);
            if (e4 !== 1'b1 || lat != 5) missed++;
            finish4();
        end
        checks++; if (missed != 0) $display("[TB] FAIL fault flagged: got %0d unflagged want 0", missed); else passed++;
        checks++; if (c4 !== 8'd255) $display("[TB] FAIL err_cnt saturate: got %0d want 255", c4); else passed++;
    endtask

    task automatic test_backpressure();
        int lat;
        start4(4'd9, 4'd11, 1'b0, 1'b0);
        wait4(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (p4 !== 8'h63 || e4 !== 1'b0 || ov4 !== 1'b1 || ir4 !== 1'b0)
                $display("[TB] FAIL hold%0d: got p=%h err=%b ov=%b ir=%b want 63 0 1 0", i, p4, e4, ov4, ir4);
            else passed++;
        end
        finish4();
        checks++; if (ir4 !== 1'b1 || ov4 !== 1'b0) $display("[TB] FAIL release: got ir=%b ov=%b want 1 0", ir4, ov4); else passed++;
        start4(4'd3, 4'd4, 1'b0, 1'b0);
        wait4(lat);
        checks++; if (p4 !== 8'd12 || lat != 5) $display("[TB] FAIL reaccept: got p=%0d lat=%0d want 12 5", p4, lat); else passed++;
        finish4();
    endtask

    task automatic test_reset_busy();
        int lat;
        int seen = 0;
        start4(4'd7, 4'd7, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (ir4 !== 1'b1) $display("[TB] FAIL midreset in_ready: got %b want 1", ir4); else passed++;
        checks++; if (ov4 !== 1'b0) $display("[TB] FAIL midreset out_valid: got %b want 0", ov4); else passed++;
        checks++; if (c4 !== 8'd0) $display("[TB] FAIL midreset err_cnt: got %0d want 0", c4); else passed++;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ov4 !== 1'b0) seen++;
        end
        checks++; if (seen != 0) $display("[TB] FAIL midreset stray: got %0d valid cycles want 0", seen); else passed++;
        start4(4'd3, 4'd5, 1'b0, 1'b0);
        wait4(lat);
        checks++; if (p4 !== 8'd15 || lat != 5) $display("[TB] FAIL after reset: got p=%0d lat=%0d want 15 5", p4, lat); else passed++;
        finish4();
    endtask

    task automatic test_sweep_w4();
        int lat;
        logic [63:0] pe;
        bit ee;
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    start4(4'(x), 4'(y), 1'(s), 1'b0);
                    wait4(lat);
                    model(4, x, y, 1'(s), 1'b0, pe, ee);
                    checks++;
                    if (lat != 5 || p4 !== pe[7:0] || e4 !== ee)
                        $display("[TB] FAIL sweep s=%0d a=%0d b=%0d: got p=%h err=%b lat=%0d want %h %b 5",
                                 s, x, y, p4, e4, lat, pe[7:0], ee);
                    else passed++;
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    finish4();
                end
            end
        end
    endtask

    task automatic test_random_w8();
        logic [63:0] pe;
        bit ee, got, done, hs;
        int n;
        for (int k = 0; k < 1500; k++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
            f8 = ($urandom_range(0, 7) == 0);
            model(8, int'(a8), int'(b8), s8, f8, pe, ee);
            iv8 = 1'b1;
            n = 0;
            while (!ir8 && n < 40) begin
                @(posedge clk); #1; n++;
            end
            @(posedge clk); #1;
            iv8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom); f8 = 1'($urandom);
            got = 0; done = 0; n = 0;
            while (!done && n < 80) begin
                if (ov8 && !got) begin
                    got = 1;
                    checks++;
                    if (p8 !== pe[15:0] || e8 !== ee)
                        $display("[TB] FAIL w8 op%0d: got p=%h err=%b want %h %b", k, p8, e8, pe[15:0], ee);
                    else passed++;
                end
                or8 = 1'($urandom);
                hs = ov8 && or8;
                @(posedge clk); #1; n++;
                if (hs) done = 1;
            end
            or8 = 1'b0;
            if (!done) begin
                checks++;
                $display("[TB] FAIL w8 op%0d timeout: got no handshake want one within 80 cycles", k);
            end
        end
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got no finish want finish before 3ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        iv4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; f4 = 1'b0; or4 = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; f8 = 1'b0; or8 = 1'b0;
        test_reset();
        test_directed();
        test_fault();
        test_backpressure();
        test_reset_busy();
        test_sweep_w4();
        test_random_w8();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
